nor_gate_bank: RTL and testbench

- Parametrised successor to the fixed triple 3-input NOR package model: CHANNELS independent INPUTS-wide NOR gates, each with per-instance initial condition and clock-counted propagation delay.
- Used by the board-level simulation wherever NOR gate packages of any width or count are instantiated.
- Adds inertial (glitch-swallowing) delay, a per-channel pending-change status and power-loss hold.

---
 rtl/nor_gate_bank_pkg.sv | 12 +
 rtl/nor_gate_channel.sv | 72 +++++++
 rtl/nor_gate_bank.sv | 43 ++++
 tb/tb_nor_gate_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_gate_bank_pkg.sv
// Shared constants and helpers for the NOR gate bank model.
package nor_gate_bank_pkg;

  localparam int NGB_DEFAULT_DELAY  = 9;
  localparam int NGB_DEFAULT_INPUTS = 3;

  // Counter wide enough to hold every value in 0..delay.
  function automatic int cnt_width(input int delay);
    return $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/nor_gate_channel.sv
// One INPUTS-wide NOR gate with clock-counted propagation delay and pending flag.
// NOR_GATE_BANK_TRANSPORT_EN selects transport delay instead of the default inertial delay.
module nor_gate_channel
  import nor_gate_bank_pkg::*;
#(
  parameter int   INPUTS = NGB_DEFAULT_INPUTS,
  parameter int   DELAY  = NGB_DEFAULT_DELAY,
  parameter logic IC_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [INPUTS-1:0] a,
  output logic              y,
  output logic              pend
);

  logic target;
  assign target = ~|a;

`ifdef NOR_GATE_BANK_TRANSPORT_EN
  logic [DELAY-1:0] stage_reg;
  logic [DELAY-1:0] stage_next;

  if (DELAY == 1) begin : g_single
    assign stage_next = target;
  end else begin : g_chain
    assign stage_next = {stage_reg[DELAY-2:0], target};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_reg <= {DELAY{IC_BIT}};
    end else if (hold) begin
      stage_reg <= {DELAY{IC_BIT}};
    end else begin
      stage_reg <= stage_next;
    end
  end

  // Oldest stage drives the pin; any younger stage disagreeing means a change is in flight.
  assign y    = stage_reg[DELAY-1];
  assign pend = |(stage_reg ^ {DELAY{stage_reg[DELAY-1]}});
`else
  localparam int CW = cnt_width(DELAY);

  logic [CW-1:0] cnt_reg;
  logic          y_reg;

  // The counter tracks how long target has disagreed with y; any agreement restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_reg   <= IC_BIT;
      cnt_reg <= '0;
    end else if (hold) begin
      y_reg   <= IC_BIT;
      cnt_reg <= '0;
    end else if (target == y_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CW'(DELAY - 1)) begin
      y_reg   <= target;
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign y    = y_reg;
  assign pend = (cnt_reg != '0);
`endif

endmodule

// File: rtl/nor_gate_bank.sv
// Bank of CHANNELS independent NOR gates sharing clock, reset and package supply.
// Optional macro NOR_GATE_BANK_TRANSPORT_EN switches every channel to transport delay.
module nor_gate_bank
  import nor_gate_bank_pkg::*;
#(
  parameter int                  CHANNELS = 3,
  parameter int                  INPUTS   = NGB_DEFAULT_INPUTS,
  parameter int                  DELAY    = NGB_DEFAULT_DELAY,
  parameter logic [CHANNELS-1:0] IC       = {CHANNELS{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vcc,
  input  logic                         gnd,
  input  logic [CHANNELS*INPUTS-1:0]   a,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          pend
);

  // Supply loss is sampled on the clock, so it behaves as a synchronous reset.
  logic power_lost;
  assign power_lost = ~vcc;

  // Ground pin exists only so board netlists connect unchanged.
  logic unused_gnd;
  assign unused_gnd = gnd;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    nor_gate_channel #(
      .INPUTS (INPUTS),
      .DELAY  (DELAY),
      .IC_BIT (IC[gi])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .hold (power_lost),
      .a    (a[gi*INPUTS +: INPUTS]),
      .y    (y[gi]),
      .pend (pend[gi])
    );
  end

endmodule

// File: tb/tb_nor_gate_bank.sv
// Self-checking bench for nor_gate_bank: DELAY=9 and DELAY=1 instances against a sample-history model.
module tb_nor_gate_bank;

  localparam logic [2:0] ICV = 3'b101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vcc = 1'b1;
  logic       gnd = 1'b0;
  logic [8:0] a   = '0;
  logic [2:0] y9, p9, y1, p1;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_y9, exp_p9, exp_y1, exp_p1;
  logic [2:0] log9[$];
  logic [2:0] log1[$];

  nor_gate_bank #(.CHANNELS(3), .INPUTS(3), .DELAY(9), .IC(ICV)) dut9 (
    .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(a), .y(y9), .pend(p9)
  );

  nor_gate_bank #(.CHANNELS(3), .INPUTS(3), .DELAY(1), .IC(ICV)) dut1 (
    .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(a), .y(y1), .pend(p1)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] targets(input logic [8:0] av);
    logic [2:0] t;
    for (int k = 0; k < 3; k++) t[k] = (av[k*3 +: 3] == 3'b000);
    return t;
  endfunction

  // q holds the most recent d target samples (oldest first).
  function automatic void eval(input int d, input logic [2:0] q[$], inout logic [2:0] y,
                               output logic [2:0] p);
    int n;
    logic [2:0] s;
    logic flip;
    n = q.size();
    p = '0;
    for (int ch = 0; ch < 3; ch++) begin
`ifdef NOR_GATE_BANK_TRANSPORT_EN
      s = q[0];
      y[ch] = s[ch];
      for (int i = 0; i < n; i++) begin
        s = q[i];
        if (s[ch] != y[ch]) p[ch] = 1'b1;
      end
`else
      // Output flips only once d consecutive samples all disagree with it.
      if (n >= d) begin
        flip = 1'b1;
        for (int i = 0; i < d; i++) begin
          s = q[n-1-i];
          if (s[ch] == y[ch]) flip = 1'b0;
        end
        if (flip) y[ch] = ~y[ch];
      end
      if (n > 0) begin
        s = q[n-1];
        p[ch] = (s[ch] != y[ch]);
      end
`endif
    end
  endfunction

  task automatic model_reset();
    log9.delete();
    log1.delete();
`ifdef NOR_GATE_BANK_TRANSPORT_EN
    for (int i = 0; i < 9; i++) log9.push_back(ICV);
    log1.push_back(ICV);
`endif
    exp_y9 = ICV; exp_p9 = '0;
    exp_y1 = ICV; exp_p1 = '0;
  endtask

  task automatic model_push(input logic [2:0] t);
    log9.push_back(t);
    if (log9.size() > 9) void'(log9.pop_front());
    log1.push_back(t);
    if (log1.size() > 1) void'(log1.pop_front());
    eval(9, log9, exp_y9, exp_p9);
    eval(1, log1, exp_y1, exp_p1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (!vcc) model_reset();
      else model_push(targets(a));
    end
    #1;
  endtask

  task automatic async_reset();
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    a = '0;
    async_reset();
    checks++;
    if (y9 !== 3'b101 || p9 !== 3'b000 || y1 !== 3'b101 || p1 !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: y=%b pend=%b y1=%b pend1=%b expected y=101 pend=000", y9, p9, y1, p1);
    end
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if ({y9, p9, y1, p1} !== {exp_y9, exp_p9, exp_y1, exp_p1}) begin
        errors++;
        $display("FAIL reset_release edge %0d: y=%b pend=%b y1=%b pend1=%b expected %b %b %b %b",
                 e, y9, p9, y1, p1, exp_y9, exp_p9, exp_y1, exp_p1);
      end
      checks++;
      if ({y9, p9} !== ((e <= 8) ? 6'b101_010 : 6'b111_000)) begin
        errors++;
        $display("FAIL reset_latency edge %0d: y=%b pend=%b expected %s", e, y9, p9,
                 (e <= 8) ? "y=101 pend=010" : "y=111 pend=000");
      end
    end
  endtask

  task automatic test_stable_change();
    a = 9'b000_000_001;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if ({y9, p9, y1, p1} !== {exp_y9, exp_p9, exp_y1, exp_p1}) begin
        errors++;
        $display("FAIL stable edge %0d: y=%b pend=%b y1=%b pend1=%b expected %b %b %b %b",
                 e, y9, p9, y1, p1, exp_y9, exp_p9, exp_y1, exp_p1);
      end
      checks++;
      if ({y9[0], p9[0]} !== ((e <= 8) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL stable_ch0 edge %0d: y0=%b pend0=%b expected y0=%0d pend0=%0d",
                 e, y9[0], p9[0], (e <= 8), (e <= 8));
      end
    end
  endtask

  task automatic test_glitch();
    logic want;
    a[8:6] = 3'b100;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 5) a[8:6] = 3'b000;
      checks++;
      if ({y9, p9, y1, p1} !== {exp_y9, exp_p9, exp_y1, exp_p1}) begin
        errors++;
        $display("FAIL glitch edge %0d: y=%b pend=%b y1=%b pend1=%b expected %b %b %b %b",
                 e, y9, p9, y1, p1, exp_y9, exp_p9, exp_y1, exp_p1);
      end
`ifdef NOR_GATE_BANK_TRANSPORT_EN
      want = !(e >= 9 && e <= 13);
`else
      want = 1'b1;
`endif
      checks++;
      if (y9[2] !== want) begin
        errors++;
        $display("FAIL glitch_y2 edge %0d: y2=%b expected %b", e, y9[2], want);
      end
    end
  endtask

  task automatic test_power_loss();
    a = 9'b000_010_001;
    for (int e = 1; e <= 14; e++) begin
      if (e == 5) vcc = 1'b0;
      tick();
      if (e == 5) begin
        vcc = 1'b1;
        checks++;
        if ({y9, p9, y1, p1} !== {3'b101, 3'b000, 3'b101, 3'b000}) begin
          errors++;
          $display("FAIL power_loss: y=%b pend=%b y1=%b pend1=%b expected y=101 pend=000", y9, p9, y1, p1);
        end
      end
      checks++;
      if ({y9, p9, y1, p1} !== {exp_y9, exp_p9, exp_y1, exp_p1}) begin
        errors++;
        $display("FAIL power edge %0d: y=%b pend=%b y1=%b pend1=%b expected %b %b %b %b",
                 e, y9, p9, y1, p1, exp_y9, exp_p9, exp_y1, exp_p1);
      end
      if (e == 13 || e == 14) begin
        checks++;
        if (y9 !== ((e == 13) ? 3'b101 : 3'b100)) begin
          errors++;
          $display("FAIL power_relatch edge %0d: y=%b expected %s", e, y9, (e == 13) ? "101" : "100");
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    a = '0;
    for (int e = 1; e <= 6; e++) tick();
    async_reset();
    checks++;
    if (y9 !== ICV || p9 !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: y=%b pend=%b expected y=101 pend=000", y9, p9);
    end
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if ({y9, p9, y1, p1} !== {exp_y9, exp_p9, exp_y1, exp_p1}) begin
        errors++;
        $display("FAIL reset_mid edge %0d: y=%b pend=%b y1=%b pend1=%b expected %b %b %b %b",
                 e, y9, p9, y1, p1, exp_y9, exp_p9, exp_y1, exp_p1);
      end
      if (e == 3 || e == 9) begin
        checks++;
        if (y9 !== ((e == 3) ? 3'b101 : 3'b111)) begin
          errors++;
          $display("FAIL reset_mid_land edge %0d: y=%b expected %s", e, y9, (e == 3) ? "101" : "111");
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    a = 9'b001_010_100;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if ({y9, p9, y1, p1} !== {exp_y9, exp_p9, exp_y1, exp_p1}) begin
        errors++;
        $display("FAIL simul edge %0d: y=%b pend=%b y1=%b pend1=%b expected %b %b %b %b",
                 e, y9, p9, y1, p1, exp_y9, exp_p9, exp_y1, exp_p1);
      end
      checks++;
      if (y9 !== ((e <= 8) ? 3'b111 : 3'b000) || y1 !== 3'b000) begin
        errors++;
        $display("FAIL simul_land edge %0d: y=%b y1=%b expected y=%s y1=000", e, y9, y1,
                 (e <= 8) ? "111" : "000");
      end
    end
  endtask

  task automatic test_random();
    int run;
    run = 0;
    for (int e = 1; e <= 400; e++) begin
      if (run == 0) begin
        for (int k = 0; k < 3; k++)
          a[k*3 +: 3] = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        run = $urandom_range(1, 12);
      end
      run--;
      vcc = ($urandom_range(0, 39) != 0);
      tick();
      checks++;
      if ({y9, p9, y1, p1} !== {exp_y9, exp_p9, exp_y1, exp_p1}) begin
        errors++;
        $display("FAIL random edge %0d: a=%b y=%b pend=%b y1=%b pend1=%b expected %b %b %b %b",
                 e, a, y9, p9, y1, p1, exp_y9, exp_p9, exp_y1, exp_p1);
      end
    end
    vcc = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_stable_change();
    test_glitch();
    test_power_loss();
    test_reset_mid_count();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
